// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared types and constants for the io_port peripheral.
//   byte_t           : one data byte on every path
//   IO_DEFAULT_DEPTH : default number of entries per FIFO
//   IO_IDLE_BYTE     : value presented on a FIFO head while it is empty
// -----------------------------------------------------------------------------
package io_pkg;

  typedef logic [7:0] byte_t;

  localparam int    IO_DEFAULT_DEPTH = 4;
  localparam byte_t IO_IDLE_BYTE     = 8'h00;

endpackage : io_pkg

// File: rtl/io_port_if.sv
// -----------------------------------------------------------------------------
// io_port_if
// Bundles the CPU-side strobes/status and both external valid/ready byte
// channels of io_port.
//   master : the environment (CPU + external producer/consumer)
//   slave  : io_port itself
// Optional: IO_LOOPBACK_EN adds the 'loopback' control bit (master -> slave).
// -----------------------------------------------------------------------------
interface io_port_if;
  import io_pkg::*;

  // CPU side
  logic  cpu_wr;
  byte_t cpu_wdata;
  logic  cpu_rd;
  byte_t cpu_rdata;
  logic  out_full;
  logic  in_empty;
  logic  ovf;
  logic  unf;
  logic  clear_flags;

  // External consumer (output FIFO drain)
  byte_t ext_out_data;
  logic  ext_out_valid;
  logic  ext_out_ready;

  // External producer (input FIFO fill)
  byte_t ext_in_data;
  logic  ext_in_valid;
  logic  ext_in_ready;

`ifdef IO_LOOPBACK_EN
  logic  loopback;

  modport master (
    output cpu_wr, cpu_wdata, cpu_rd, clear_flags,
    output ext_out_ready, ext_in_data, ext_in_valid, loopback,
    input  cpu_rdata, out_full, in_empty, ovf, unf,
    input  ext_out_data, ext_out_valid, ext_in_ready
  );

  modport slave (
    input  cpu_wr, cpu_wdata, cpu_rd, clear_flags,
    input  ext_out_ready, ext_in_data, ext_in_valid, loopback,
    output cpu_rdata, out_full, in_empty, ovf, unf,
    output ext_out_data, ext_out_valid, ext_in_ready
  );
`else
  modport master (
    output cpu_wr, cpu_wdata, cpu_rd, clear_flags,
    output ext_out_ready, ext_in_data, ext_in_valid,
    input  cpu_rdata, out_full, in_empty, ovf, unf,
    input  ext_out_data, ext_out_valid, ext_in_ready
  );

  modport slave (
    input  cpu_wr, cpu_wdata, cpu_rd, clear_flags,
    input  ext_out_ready, ext_in_data, ext_in_valid,
    output cpu_rdata, out_full, in_empty, ovf, unf,
    output ext_out_data, ext_out_valid, ext_in_ready
  );
`endif

endinterface : io_port_if

// File: rtl/io_fifo.sv
// -----------------------------------------------------------------------------
// io_fifo
// Circular-buffer byte FIFO with combinational head.
//   clock, reset : clock, async active-high reset (clears pointers/count)
//   push         : request to enqueue push_data (taken when !full, or when
//                  full and a pop happens in the same cycle)
//   push_data    : byte to enqueue
//   pop          : request to dequeue head (ignored while empty)
//   head         : current head byte, IO_IDLE_BYTE while empty
//   full, empty  : count == DEPTH / count == 0
//   count        : number of stored entries
// -----------------------------------------------------------------------------
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IO_DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  byte_t                    push_data,
  input  logic                     pop,
  output byte_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  byte_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // When full, the slot under the write pointer is the head being popped
  // this same cycle, so overwriting it at the edge is safe.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign head = empty ? IO_IDLE_BYTE : r_mem[r_rptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are unreachable until
  // written because head is masked by 'empty', and leaving the array
  // reset-free keeps it mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

endmodule : io_fifo

// File: rtl/io_port.sv
// -----------------------------------------------------------------------------
// io_port
// Byte-wide CPU I/O peripheral: CPU writes go into an output FIFO drained by
// an external consumer; bytes from an external producer fill an input FIFO
// whose head the CPU reads.
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : io_port_if.slave -- CPU strobes/status, ext_out_* and ext_in_*
//           channels, sticky ovf/unf flags with clear_flags
// Optional: define IO_LOOPBACK_EN to add bus.loopback, which routes the
// output FIFO head straight into the input FIFO and masks the external
// handshakes.
// -----------------------------------------------------------------------------
module io_port
  import io_pkg::*;
#(
  parameter int DEPTH = IO_DEFAULT_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  io_port_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);

  byte_t          w_out_head;
  logic           w_out_full;
  logic           w_out_empty;
  logic [PTR_W:0] w_out_count;

  byte_t          w_in_head;
  logic           w_in_full;
  logic           w_in_empty;
  logic [PTR_W:0] w_in_count;

  logic           w_out_pop;
  logic           w_in_push;
  byte_t          w_in_push_data;
  logic           w_ovf_evt;
  logic           w_unf_evt;

  logic           r_ovf;
  logic           r_unf;

  // Counts are kept on the FIFO interface for debug/status visibility.
  logic           w_unused_counts;
  assign w_unused_counts = ^{w_out_count, w_in_count};

  // Transfer selection between the external handshakes and loopback.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    w_out_pop      = bus.ext_out_ready && !w_out_empty;
    w_in_push      = bus.ext_in_valid && !w_in_full;
    w_in_push_data = bus.ext_in_data;
`ifdef IO_LOOPBACK_EN
    if (bus.loopback) begin
      w_out_pop      = !w_out_empty && !w_in_full;
      w_in_push      = w_out_pop;
      w_in_push_data = w_out_head;
    end
`endif
  end

  io_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.cpu_wr),
    .push_data (bus.cpu_wdata),
    .pop       (w_out_pop),
    .head      (w_out_head),
    .full      (w_out_full),
    .empty     (w_out_empty),
    .count     (w_out_count)
  );

  io_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_in_push),
    .push_data (w_in_push_data),
    .pop       (bus.cpu_rd),
    .head      (w_in_head),
    .full      (w_in_full),
    .empty     (w_in_empty),
    .count     (w_in_count)
  );

  // A write into a full FIFO survives only if the head leaves the same cycle.
  // A read of an empty FIFO is an underflow even if a push lands alongside.
  assign w_ovf_evt = bus.cpu_wr && w_out_full && !w_out_pop;
  assign w_unf_evt = bus.cpu_rd && w_in_empty;

  // Sticky flags: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_evt)            r_ovf <= 1'b1;
      else if (bus.clear_flags) r_ovf <= 1'b0;
      if (w_unf_evt)            r_unf <= 1'b1;
      else if (bus.clear_flags) r_unf <= 1'b0;
    end
  end

  assign bus.cpu_rdata    = w_in_head;
  assign bus.in_empty     = w_in_empty;
  assign bus.out_full     = w_out_full;
  assign bus.ovf          = r_ovf;
  assign bus.unf          = r_unf;
  assign bus.ext_out_data = w_out_head;
`ifdef IO_LOOPBACK_EN
  assign bus.ext_out_valid = !w_out_empty && !bus.loopback;
  assign bus.ext_in_ready  = !w_in_full && !bus.loopback;
`else
  assign bus.ext_out_valid = !w_out_empty;
  assign bus.ext_in_ready  = !w_in_full;
`endif

endmodule : io_port
